uart_cal_parser: RTL and testbench

//  Consumes ASCII bytes from the UART receiver and parses calculator expressions "<A><op><B>=".

---
 rtl/cal_pkg.sv | 70 +++++++
 rtl/cal_dec_acc.sv | 58 +++++
 rtl/uart_cal_parser.sv | 141 ++++++++++++++
 tb/tb_uart_cal_parser.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
// Shared definitions for the UART calculator parser: opcodes, ASCII
// constants, parser state encoding and byte classification helpers.
package cal_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_STAR  = 8'h2A;
    localparam logic [7:0] ASC_SLASH = 8'h2F;
    localparam logic [7:0] ASC_EQ    = 8'h3D;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_I     = 8'h49;
    localparam logic [7:0] ASC_U     = 8'h55;
    localparam logic [7:0] ASC_S     = 8'h53;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPA,
        ST_OPB,
        ST_ISSUE,
        ST_ERR
    } state_e;

    typedef enum logic [2:0] {
        CLS_DIGIT,
        CLS_OP,
        CLS_EQ,
        CLS_SP,
        CLS_CLR,
        CLS_UNS,
        CLS_SGN,
        CLS_BAD
    } cls_e;

    function automatic cls_e classify(input logic [7:0] b);
        cls_e cls;
        if (b >= ASC_0 && b <= ASC_9) begin
            cls = CLS_DIGIT;
        end else begin
            case (b)
                ASC_PLUS, ASC_MINUS, ASC_STAR, ASC_SLASH: cls = CLS_OP;
                ASC_EQ:  cls = CLS_EQ;
                ASC_SP:  cls = CLS_SP;
                ASC_I:   cls = CLS_CLR;
                ASC_U:   cls = CLS_UNS;
                ASC_S:   cls = CLS_SGN;
                default: cls = CLS_BAD;
            endcase
        end
        return cls;
    endfunction

    function automatic logic [1:0] op_of(input logic [7:0] b);
        logic [1:0] op;
        case (b)
            ASC_MINUS: op = OP_SUB;
            ASC_STAR:  op = OP_MUL;
            ASC_SLASH: op = OP_DIV;
            default:   op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cal_dec_acc.sv
// Decimal accumulator: clear, load a first digit, or step acc = acc*10 + digit.
// Build option UART_CAL_OVF_DET_EN: when defined, ovf flags a step whose true
// result does not fit in DATA_W bits; otherwise ovf is tied low and the
// accumulator wraps modulo 2^DATA_W.
module cal_dec_acc #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clr,
    input  logic              load,
    input  logic              step,
    input  logic [3:0]        digit,
    output logic [DATA_W-1:0] acc,
    output logic              ovf
);

    logic [DATA_W-1:0] acc_q, acc_d;

`ifdef UART_CAL_OVF_DET_EN
    // Four guard bits hold acc*10+9 for any DATA_W-bit acc.
    logic [DATA_W+3:0] step_wide;
    assign step_wide = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1)
                     + {{DATA_W{1'b0}}, digit};
    assign ovf       = |step_wide[DATA_W+3:DATA_W];
    wire [DATA_W-1:0] step_val = step_wide[DATA_W-1:0];
`else
    wire [DATA_W-1:0] step_val = (acc_q << 3) + (acc_q << 1)
                               + {{(DATA_W-4){1'b0}}, digit};
    assign ovf = 1'b0;
`endif

    // Next accumulator value; clear has priority over load and step.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (load) begin
            acc_d = {{(DATA_W-4){1'b0}}, digit};
        end else if (step) begin
            acc_d = step_val;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!n_rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/uart_cal_parser.sv
// Parses ASCII calculator expressions "<A><op><B>=" from the UART receiver
// and hands one (A, B, opcode) command per '=' to the ALU over valid/ready.
// Build option UART_CAL_OVF_DET_EN (in cal_dec_acc): operand overflow -> ERR.
module uart_cal_parser
    import cal_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic [1:0]        opcode,
    output logic              signed_mode,
    output logic              err,
    output logic              overrun
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] opa_q, opb_q;
    logic [1:0]        opcode_q, opcode_d;
    logic              signed_q, signed_d;
    logic              has_dig_q, has_dig_d;
    logic              overrun_q, overrun_d;
    logic              opa_we, opb_we;
    logic              acc_clr, acc_load, acc_step, acc_ovf;
    logic [DATA_W-1:0] acc;
    cls_e              cls;

    assign cls = classify(rx_data);

    // Digits are 0x30..0x39, so the low nibble equals rx_data - 8'h30.
    cal_dec_acc #(.DATA_W(DATA_W)) u_acc (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (acc_clr),
        .load  (acc_load),
        .step  (acc_step),
        .digit (rx_data[3:0]),
        .acc   (acc),
        .ovf   (acc_ovf)
    );

    // Next-state and control decode for one received byte per cycle.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        signed_d  = signed_q;
        has_dig_d = has_dig_q;
        overrun_d = 1'b0;
        opa_we    = 1'b0;
        opb_we    = 1'b0;
        acc_clr   = 1'b0;
        acc_load  = 1'b0;
        acc_step  = 1'b0;

        if (state_q == ST_ISSUE) begin
            // Command pending: any byte is lost, the handshake still completes.
            overrun_d = rx_valid;
            if (cmd_ready) begin
                state_d = ST_IDLE;
            end
        end else if (rx_valid) begin
            if (cls == CLS_CLR) begin
                acc_clr = 1'b1;
                state_d = ST_IDLE;
            end else if (state_q != ST_ERR) begin
                case (cls)
                    CLS_SP:  ;
                    CLS_UNS: signed_d = 1'b0;
                    CLS_SGN: signed_d = 1'b1;
                    CLS_DIGIT: begin
                        if (state_q == ST_IDLE) begin
                            acc_load = 1'b1;
                            state_d  = ST_OPA;
                        end else if (acc_ovf) begin
                            state_d = ST_ERR;
                        end else begin
                            acc_step  = 1'b1;
                            has_dig_d = 1'b1;
                        end
                    end
                    CLS_OP: begin
                        if (state_q == ST_OPA) begin
                            opa_we    = 1'b1;
                            opcode_d  = op_of(rx_data);
                            acc_clr   = 1'b1;
                            has_dig_d = 1'b0;
                            state_d   = ST_OPB;
                        end else begin
                            state_d = ST_ERR;
                        end
                    end
                    CLS_EQ: begin
                        if (state_q == ST_OPB && has_dig_q) begin
                            opb_we  = 1'b1;
                            state_d = ST_ISSUE;
                        end else begin
                            state_d = ST_ERR;
                        end
                    end
                    default: state_d = ST_ERR;
                endcase
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            opcode_q  <= OP_ADD;
            signed_q  <= 1'b0;
            has_dig_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            signed_q  <= signed_d;
            has_dig_q <= has_dig_d;
            overrun_q <= overrun_d;
            if (opa_we) opa_q <= acc;
            if (opb_we) opb_q <= acc;
        end
    end

    assign cmd_valid   = (state_q == ST_ISSUE);
    assign err         = (state_q == ST_ERR);
    assign operand_a   = opa_q;
    assign operand_b   = opb_q;
    assign opcode      = opcode_q;
    assign signed_mode = signed_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_cal_parser.sv
// Directed self-checking bench for uart_cal_parser (DATA_W = 16).
// Honours UART_CAL_OVF_DET_EN for the overflow expectations.
module tb_uart_cal_parser;

    localparam int DATA_W = 16;

    logic              clk;
    logic              n_rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [1:0]        opcode;
    logic              signed_mode;
    logic              err;
    logic              overrun;

    int checks = 0;
    int errors = 0;

    uart_cal_parser #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .opcode      (opcode),
        .signed_mode (signed_mode),
        .err         (err),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one byte for one cycle; returns on the following falling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    // One-cycle cmd_ready pulse; returns on the falling edge after it.
    task automatic accept();
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   {31'd0, cmd_valid},   32'd0);
        check({tag, "_a"},       {16'd0, operand_a},   32'd0);
        check({tag, "_b"},       {16'd0, operand_b},   32'd0);
        check({tag, "_op"},      {30'd0, opcode},      32'd0);
        check({tag, "_signed"},  {31'd0, signed_mode}, 32'd0);
        check({tag, "_err"},     {31'd0, err},         32'd0);
        check({tag, "_overrun"}, {31'd0, overrun},     32'd0);
    endtask

    initial begin
        n_rst     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        cmd_ready = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // "12+34=": command one cycle after '='
        send_str("12+34");
        check("add_not_yet", {31'd0, cmd_valid}, 32'd0);
        send_byte("=");
        check("add_valid", {31'd0, cmd_valid}, 32'd1);
        check("add_a", {16'd0, operand_a}, 32'd12);
        check("add_b", {16'd0, operand_b}, 32'd34);
        check("add_op", {30'd0, opcode}, 32'd0);
        accept();
        check("add_done", {31'd0, cmd_valid}, 32'd0);

        // "S7 * 6=": spaces ignored, signed mode set
        send_str("S7 * 6=");
        check("mul_valid", {31'd0, cmd_valid}, 32'd1);
        check("mul_a", {16'd0, operand_a}, 32'd7);
        check("mul_b", {16'd0, operand_b}, 32'd6);
        check("mul_op", {30'd0, opcode}, 32'd2);
        check("mul_signed", {31'd0, signed_mode}, 32'd1);
        accept();

        // "5+=": missing second operand
        send_str("5+=");
        check("syn_err", {31'd0, err}, 32'd1);
        check("syn_no_cmd", {31'd0, cmd_valid}, 32'd0);
        send_str("9/3=");
        check("err_sticky", {31'd0, err}, 32'd1);
        check("err_no_cmd", {31'd0, cmd_valid}, 32'd0);
        send_byte("I");
        check("clr_err", {31'd0, err}, 32'd0);
        send_str("9/3=");
        check("div_valid", {31'd0, cmd_valid}, 32'd1);
        check("div_a", {16'd0, operand_a}, 32'd9);
        check("div_b", {16'd0, operand_b}, 32'd3);
        check("div_op", {30'd0, opcode}, 32'd3);
        accept();

        // Unknown byte is a syntax error; 'U' clears signed mode
        send_byte("x");
        check("bad_err", {31'd0, err}, 32'd1);
        send_byte("U");
        check("u_in_err", {31'd0, signed_mode}, 32'd1);
        send_str("I U");
        check("u_signed", {31'd0, signed_mode}, 32'd0);
        check("u_err", {31'd0, err}, 32'd0);

        // "1-2=" held pending, bytes dropped with overrun
        send_str("1-2=");
        check("sub_a", {16'd0, operand_a}, 32'd1);
        check("sub_b", {16'd0, operand_b}, 32'd2);
        check("sub_op", {30'd0, opcode}, 32'd1);
        repeat (20) @(negedge clk);
        check("hold_valid", {31'd0, cmd_valid}, 32'd1);
        check("hold_ovr0", {31'd0, overrun}, 32'd0);
        send_byte("4");
        check("ovr_pulse", {31'd0, overrun}, 32'd1);
        @(negedge clk);
        check("ovr_low", {31'd0, overrun}, 32'd0);
        check("ovr_a", {16'd0, operand_a}, 32'd1);
        check("ovr_b", {16'd0, operand_b}, 32'd2);
        check("ovr_valid", {31'd0, cmd_valid}, 32'd1);
        send_byte("I");
        check("i_in_issue_valid", {31'd0, cmd_valid}, 32'd1);
        check("i_in_issue_ovr", {31'd0, overrun}, 32'd1);
        // Byte coincident with cmd_ready: handshake completes, byte dropped
        @(negedge clk);
        rx_data   = "7";
        rx_valid  = 1'b1;
        cmd_ready = 1'b1;
        @(negedge clk);
        rx_valid  = 1'b0;
        cmd_ready = 1'b0;
        check("coinc_valid", {31'd0, cmd_valid}, 32'd0);
        check("coinc_ovr", {31'd0, overrun}, 32'd1);
        send_str("2+5=");
        check("after_coinc_a", {16'd0, operand_a}, 32'd2);
        check("after_coinc_b", {16'd0, operand_b}, 32'd5);
        accept();

        // Largest representable operand never overflows
        send_str("65535+0=");
        check("max_err", {31'd0, err}, 32'd0);
        check("max_a", {16'd0, operand_a}, 32'd65535);
        accept();

        // "65536+1=": overflow detection or wrap
        send_str("65536+1=");
`ifdef UART_CAL_OVF_DET_EN
        check("ovf_err", {31'd0, err}, 32'd1);
        check("ovf_no_cmd", {31'd0, cmd_valid}, 32'd0);
        send_byte("I");
`else
        check("wrap_err", {31'd0, err}, 32'd0);
        check("wrap_a", {16'd0, operand_a}, 32'd0);
        check("wrap_b", {16'd0, operand_b}, 32'd1);
        accept();
`endif

        // Reset in the middle of "12+3" with signed mode set
        send_str("S12+3");
        check("pre_rst_a", {16'd0, operand_a}, 32'd12);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        n_rst = 1'b1;
        send_str("8+1=");
        check("post_rst_valid", {31'd0, cmd_valid}, 32'd1);
        check("post_rst_a", {16'd0, operand_a}, 32'd8);
        check("post_rst_b", {16'd0, operand_b}, 32'd1);
        accept();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
